// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of N non-FWFT source FIFOs into a 2-entry credit-checked output buffer.
// Optional per-channel popped-word counters on stat_words when FIFO_RR_ARBITER_STATS_EN is defined.
module fifo_rr_arbiter #(
    parameter int pCHANNELS   = 4,
    parameter int pDATA_WIDTH = 16,
    parameter int pBURST      = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [pCHANNELS-1:0]             ch_empty,
    output logic [pCHANNELS-1:0]             ch_ren,
    input  logic [pCHANNELS*pDATA_WIDTH-1:0] ch_rdata,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [pDATA_WIDTH-1:0]           out_data,
    output logic [2:0]                       out_channel,
    output logic                             busy
`ifdef FIFO_RR_ARBITER_STATS_EN
    ,
    output logic [pCHANNELS*32-1:0]          stat_words
`endif
);

    localparam int CW = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, ARB, BURST} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          last_grant_q, last_grant_d;
    logic [CW-1:0]          grant_q, grant_d;
    logic [7:0]             burst_cnt_q, burst_cnt_d;
    logic                   inflight_q, inflight_d;
    logic [CW-1:0]          inflight_ch_q, inflight_ch_d;
    logic [pDATA_WIDTH-1:0] buf_data_q [2];
    logic [pDATA_WIDTH-1:0] buf_data_d [2];
    logic [CW-1:0]          buf_ch_q [2];
    logic [CW-1:0]          buf_ch_d [2];
    logic [1:0]             count_q, count_d;

    logic [pDATA_WIDTH-1:0] rdata_arr [pCHANNELS];
    logic                   pop;
    logic [1:0]             occ_after_pop;
    logic                   credit;
    logic                   issue;
    logic                   arb_found;
    logic [CW-1:0]          arb_ch;
    logic [CW-1:0]          arb_idx;

    genvar gi;
    generate
        for (gi = 0; gi < pCHANNELS; gi++) begin : g_chan
            assign rdata_arr[gi] = ch_rdata[gi*pDATA_WIDTH +: pDATA_WIDTH];
            assign ch_ren[gi]    = issue && (grant_q == CW'(gi));
        end
    endgenerate

    assign out_valid     = (count_q != 2'd0);
    assign out_data      = buf_data_q[0];
    assign out_channel   = 3'(buf_ch_q[0]);
    assign pop           = out_valid && out_ready;
    assign occ_after_pop = count_q - {1'b0, pop};
    // Reads in flight must still find room once they land a cycle later.
    assign credit        = (occ_after_pop + {1'b0, inflight_q}) < 2'd2;
    assign busy          = (state_q != IDLE) || inflight_q || (count_q != 2'd0);

    always_comb begin
        arb_found = 1'b0;
        arb_ch    = last_grant_q;
        arb_idx   = '0;
        for (int i = 1; i <= pCHANNELS; i++) begin
            arb_idx = CW'((int'(last_grant_q) + i) % pCHANNELS);
            if (!arb_found && !ch_empty[arb_idx]) begin
                arb_found = 1'b1;
                arb_ch    = arb_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        burst_cnt_d  = burst_cnt_q;
        issue        = 1'b0;
        case (state_q)
            IDLE: begin
                if (ch_empty != '1) state_d = ARB;
            end
            ARB: begin
                if (arb_found) begin
                    grant_d      = arb_ch;
                    last_grant_d = arb_ch;
                    burst_cnt_d  = 8'd0;
                    state_d      = BURST;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                // Without credit the burst simply waits, even if the source ran dry.
                if (credit) begin
                    if (!ch_empty[grant_q]) begin
                        issue       = 1'b1;
                        burst_cnt_d = burst_cnt_q + 8'd1;
                        if (burst_cnt_q == 8'(pBURST - 1)) state_d = ARB;
                    end else begin
                        state_d = ARB;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_data_d[0] = buf_data_q[0];
        buf_data_d[1] = buf_data_q[1];
        buf_ch_d[0]   = buf_ch_q[0];
        buf_ch_d[1]   = buf_ch_q[1];
        inflight_d    = issue;
        inflight_ch_d = grant_q;
        count_d       = occ_after_pop + {1'b0, inflight_q};
        if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_ch_d[0]   = buf_ch_q[1];
        end
        if (inflight_q) begin
            if (occ_after_pop == 2'd0) begin
                buf_data_d[0] = rdata_arr[inflight_ch_q];
                buf_ch_d[0]   = inflight_ch_q;
            end else begin
                buf_data_d[1] = rdata_arr[inflight_ch_q];
                buf_ch_d[1]   = inflight_ch_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= CW'(pCHANNELS - 1);
            grant_q       <= '0;
            burst_cnt_q   <= 8'd0;
            inflight_q    <= 1'b0;
            inflight_ch_q <= '0;
            count_q       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_ch_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            burst_cnt_q   <= burst_cnt_d;
            inflight_q    <= inflight_d;
            inflight_ch_q <= inflight_ch_d;
            count_q       <= count_d;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= buf_data_d[i];
                buf_ch_q[i]   <= buf_ch_d[i];
            end
        end
    end

`ifdef FIFO_RR_ARBITER_STATS_EN
    generate
        for (gi = 0; gi < pCHANNELS; gi++) begin : g_stat
            logic [31:0] stat_q, stat_d;
            always_comb begin
                stat_d = stat_q;
                if (pop && (buf_ch_q[0] == CW'(gi)) && (stat_q != 32'hFFFF_FFFF))
                    stat_d = stat_q + 32'd1;
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) stat_q <= 32'd0;
                else       stat_q <= stat_d;
            end
            assign stat_words[gi*32 +: 32] = stat_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: source FIFO models feed expected words as they are read.
module tb_fifo_rr_arbiter;
    localparam int NCH = 4;
    localparam int W   = 16;

    typedef struct packed {
        logic [2:0]   ch;
        logic [W-1:0] data;
    } word_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NCH-1:0]     ch_empty = '1;
    logic [NCH-1:0]     ch_ren;
    logic [NCH*W-1:0]   ch_rdata = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [W-1:0]       out_data;
    logic [2:0]         out_channel;
    logic               busy;
`ifdef FIFO_RR_ARBITER_STATS_EN
    logic [NCH*32-1:0]  stat_words;
`endif

    fifo_rr_arbiter #(.pCHANNELS(NCH), .pDATA_WIDTH(W), .pBURST(8)) dut (
        .clk(clk), .reset(reset), .ch_empty(ch_empty), .ch_ren(ch_ren), .ch_rdata(ch_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_channel(out_channel), .busy(busy)
`ifdef FIFO_RR_ARBITER_STATS_EN
        , .stat_words(stat_words)
`endif
    );

    always #5 clk = ~clk;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] src_q [NCH][$];
    word_t        exp_q [$];
    logic [NCH-1:0] ren_s = '0;
    int           rd_cnt = 0;
    int           pop_cnt = 0;
    int           cycle = 0;
    int           tag = 0;
    int           run_ch [$];
    int           run_len [$];
    int           pop_cycle [$];
    logic         last_stall = 1'b0;
    logic [W-1:0] last_data = '0;
    logic [W-1:0] model_w;
    word_t        mon_e;

    // Source FIFO model: a read seen during cycle t presents its word just after the edge ending t.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                if (ren_s[i] && src_q[i].size() > 0) begin
                    model_w = src_q[i].pop_front();
                    ch_rdata[i*W +: W] = model_w;
                    exp_q.push_back({3'(i), model_w});
                end
            end
        end
        for (int i = 0; i < NCH; i++) ch_empty[i] = (src_q[i].size() == 0);
    end

    always @(negedge clk) begin
        cycle++;
        if (reset) begin
            ren_s = '0;
            rd_cnt = 0;
            pop_cnt = 0;
            last_stall = 1'b0;
        end else begin
            ren_s = ch_ren;
            vectors++;
            if (!$onehot0(ch_ren) || ((ch_ren & ch_empty) != '0)) begin
                miscompares++;
                $display("FAIL ren_legal: ren=%b empty=%b", ch_ren, ch_empty);
            end
            if (last_stall) begin
                vectors++;
                if (!out_valid || out_data !== last_data) begin
                    miscompares++;
                    $display("FAIL hold: valid=%b data=%h required data=%h", out_valid, out_data, last_data);
                end
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                pop_cycle.push_back(cycle);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: ch=%0d data=%h", out_channel, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({out_channel, out_data} !== mon_e) begin
                        miscompares++;
                        $display("FAIL word: ch=%0d data=%h required ch=%0d data=%h",
                                 out_channel, out_data, mon_e.ch, mon_e.data);
                    end
                end
            end
            if (ch_ren != '0) begin
                rd_cnt++;
                for (int i = 0; i < NCH; i++) begin
                    if (ch_ren[i]) begin
                        if (run_ch.size() > 0 && run_ch[$] == i) run_len[$] = run_len[$] + 1;
                        else begin
                            run_ch.push_back(i);
                            run_len.push_back(1);
                        end
                    end
                end
            end
            vectors++;
            if (rd_cnt - pop_cnt > 2) begin
                miscompares++;
                $display("FAIL occupancy: %0d words buffered or in flight, limit 2", rd_cnt - pop_cnt);
            end
            last_stall = out_valid && !out_ready;
            last_data  = out_data;
        end
    end

    task automatic load(input int ch, input int n);
        for (int k = 0; k < n; k++) src_q[ch].push_back(W'((ch << 12) | ((tag & 15) << 8) | k));
        tag++;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        for (int i = 0; i < NCH; i++) src_q[i].delete();
        ch_empty = '1;
        exp_q.delete();
        run_ch.delete();
        run_len.delete();
        pop_cycle.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (busy) begin
            miscompares++;
            $display("FAIL %s_timeout: busy still high after %0d cycles", name, budget);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_leftover: %0d words not output, required 0", name, exp_q.size());
        end
    endtask

    task automatic check_runs(input string name, input int n, input int chs[8], input int lens[8]);
        vectors++;
        if (run_ch.size() != n) begin
            miscompares++;
            $display("FAIL %s_bursts: %0d bursts seen, required %0d", name, run_ch.size(), n);
        end
        for (int i = 0; i < n && i < run_ch.size(); i++) begin
            vectors++;
            if (run_ch[i] != chs[i] || run_len[i] != lens[i]) begin
                miscompares++;
                $display("FAIL %s_burst%0d: ch=%0d len=%0d required ch=%0d len=%0d",
                         name, i, run_ch[i], run_len[i], chs[i], lens[i]);
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (out_valid !== 1'b0 || ch_ren !== '0 || busy !== 1'b0 || out_data !== '0 || out_channel !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b ren=%b busy=%b data=%h ch=%0d required all 0",
                     out_valid, ch_ren, busy, out_data, out_channel);
        end
        @(posedge clk); #2 reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        int gap, want;
        do_reset();
        out_ready = 1'b1;
        load(0, 20);
        wait_drain("single", 200);
        vectors++;
        if (pop_cycle.size() != 20) begin
            miscompares++;
            $display("FAIL single_count: %0d words, required 20", pop_cycle.size());
        end
        for (int k = 1; k < 20 && k < pop_cycle.size(); k++) begin
            gap  = pop_cycle[k] - pop_cycle[k-1];
            want = (k == 8 || k == 16) ? 2 : 1;
            vectors++;
            if (gap != want) begin
                miscompares++;
                $display("FAIL single_gap%0d: gap=%0d required %0d", k, gap, want);
            end
        end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        int chs[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
        int lens[8] = '{8, 8, 8, 8, 2, 2, 2, 2};
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < NCH; c++) load(c, 10);
        wait_drain("rr", 300);
        check_runs("rr", 8, chs, lens);
        $display("test_round_robin done");
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        out_ready = 1'b1;
        load(0, 12);
        n = 0;
        while (pop_cnt < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #2 out_ready = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (rd_cnt - pop_cnt != 2 || ch_ren !== '0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_stall: held=%0d ren=%b valid=%b required held=2 ren=0 valid=1",
                     rd_cnt - pop_cnt, ch_ren, out_valid);
        end
        @(posedge clk); #2 out_ready = 1'b1;
        wait_drain("bp", 200);
        vectors++;
        if (pop_cnt != 12) begin
            miscompares++;
            $display("FAIL bp_total: %0d words, required 12", pop_cnt);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_channel_empties();
        int chs[8]  = '{2, 3, 0, 0, 0, 0, 0, 0};
        int lens[8] = '{3, 4, 0, 0, 0, 0, 0, 0};
        do_reset();
        out_ready = 1'b1;
        load(2, 3);
        load(3, 4);
        wait_drain("empty", 200);
        check_runs("empty", 2, chs, lens);
        $display("test_channel_empties done");
    endtask

    task automatic test_reset_mid_burst();
        int chs[8]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        int lens[8] = '{4, 5, 0, 0, 0, 0, 0, 0};
        do_reset();
        out_ready = 1'b0;
        load(0, 6);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ch_ren !== '0) begin
            miscompares++;
            $display("FAIL midreset: valid=%b busy=%b ren=%b required 0", out_valid, busy, ch_ren);
        end
        exp_q.delete();
        run_ch.delete();
        run_len.delete();
        vectors++;
        if (src_q[0].size() != 4) begin
            miscompares++;
            $display("FAIL midreset_reads: %0d words left in ch0, required 4", src_q[0].size());
        end
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        load(1, 5);
        out_ready = 1'b1;
        wait_drain("midreset", 200);
        check_runs("midreset", 2, chs, lens);
        $display("test_reset_mid_burst done");
    endtask

`ifdef FIFO_RR_ARBITER_STATS_EN
    task automatic test_stats();
        logic [31:0] want [NCH];
        do_reset();
        want = '{32'd0, 32'd5, 32'd0, 32'd3};
        out_ready = 1'b1;
        load(1, 5);
        load(3, 3);
        wait_drain("stats", 200);
        for (int c = 0; c < NCH; c++) begin
            vectors++;
            if (stat_words[c*32 +: 32] !== want[c]) begin
                miscompares++;
                $display("FAIL stat_ch%0d: %0d required %0d", c, stat_words[c*32 +: 32], want[c]);
            end
        end
        $display("test_stats done");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_channel_empties();
        test_reset_mid_burst();
`ifdef FIFO_RR_ARBITER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 SHALL have parameter pCHANNELS, default 4, number of source FIFOs (2..8).
REQ-002 SHALL have parameter pDATA_WIDTH, default 16, word width.
REQ-003 SHALL have parameter pBURST, default 8, maximum words drained per grant (1..255).
REQ-004 SHALL have port clk  input  1  sole clock; all logic is on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ch_empty  input  pCHANNELS  per-channel source FIFO empty flag.
REQ-007 SHALL have port ch_ren  output  pCHANNELS  per-channel source FIFO read enable (non-FWFT, 1-cycle read latency).
REQ-008 SHALL have port ch_rdata  input  pCHANNELS*pDATA_WIDTH  per-channel read data; channel i occupies bits [i*W +: W].
REQ-009 SHALL have port out_valid  output  1  output word available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-011 SHALL have port out_data  output  pDATA_WIDTH  output word.
REQ-012 SHALL have port out_channel  output  3  source channel of out_data.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE or words are in flight or buffered.

Function
REQ-014 SHALL implement states IDLE, ARB and BURST.
REQ-015 IDLE SHALL go to ARB when any ch_empty bit is low.
REQ-016 ARB SHALL grant, in one cycle, the first non-empty channel searching upward (with wrap) from last_grant+1, then enter BURST; last_grant resets to pCHANNELS-1, so channel 0 wins first.
REQ-017 ARB SHALL go to IDLE if all channels are empty.
REQ-018 BURST SHALL assert ch_ren[grant] in a cycle only when ch_empty[grant]=0 and credit is available (REQ-020).
REQ-019 BURST SHALL return to ARB after pBURST reads are issued, or in the first cycle in which ch_empty[grant]=1 and credit is available.
REQ-020 Data SHALL pass through a 2-entry output buffer; credit is available when occupancy after this cycle's pop plus reads in flight is less than 2.
REQ-021 Data from a ren issued in cycle t SHALL be written into the buffer at the end of cycle t+1, tagged with the channel.
REQ-022 At most one ch_ren bit SHALL be high in any cycle, and never for a channel whose ch_empty is high.
REQ-023 out_valid/out_data/out_channel SHALL present the buffer head; a pop occurs when out_valid&out_ready; out_data SHALL hold stable while out_valid&!out_ready.
REQ-024 With out_ready held high and a single non-empty channel, sustained throughput SHALL be 1 word/cycle, with 1 ARB bubble cycle every pBURST words.
REQ-025 Words SHALL be output in issue order; no word SHALL be dropped or duplicated.
REQ-026 The burst counter SHALL be 8 bits; it clears on entry to BURST and increments per issued ren.

Reset
REQ-027 On reset, state=IDLE, last_grant=pCHANNELS-1, burst counter=0, buffer emptied, in-flight cleared.
REQ-028 During reset, ch_ren=0, out_valid=0, out_data=0, out_channel=0, busy=0.
REQ-029 Reset asserted mid-burst SHALL discard buffered and in-flight words.

Configuration
REQ-030 With macro FIFO_RR_ARBITER_STATS_EN defined, the block SHALL add output stat_words (pCHANNELS*32): per-channel count of popped words, saturating at 32'hFFFFFFFF, cleared by reset.
REQ-031 Without FIFO_RR_ARBITER_STATS_EN, stat_words and its counters SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Single channel: ch0 holds 20 words, out_ready=1, pBURST=8 -> 20 words in order with out_channel=0; bubbles after words 8 and 16; busy then falls.
REQ-033 Round robin: ch0..ch3 each hold 10 words -> grant order 0,1,2,3,0,1,2,3 with bursts of 8,8,8,8,2,2,2,2.
REQ-034 Backpressure: out_ready=0 for 10 cycles mid-burst -> at most 2 words buffered, ch_ren low once credit is exhausted, out_data stable, no loss after out_ready=1.
REQ-035 Channel 2 empties after 3 words of a burst -> exactly 3 words from ch2, then ARB grants ch3; ch_ren[2] is never high while ch_empty[2]=1.
REQ-036 Reset pulse while 2 words are buffered -> out_valid=0 immediately; after release the first grant goes to channel 0.
REQ-037 With FIFO_RR_ARBITER_STATS_EN: 5 words from ch1 and 3 from ch3 -> stat_words ch1=5, ch3=3, others 0.
